// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder/subtractor with start/done handshake
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ra, rb, acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sum_bit, carry_out, accept;

  always_comb begin
    sum_bit   = ra[0] ^ rb[0] ^ carry;
    carry_out = (ra[0] & rb[0]) | (ra[0] & carry) | (rb[0] & carry);
    accept    = (state != RUN) && start;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Subtraction folds into addition: invert B once at accept, seed carry with 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra    <= '0;
      rb    <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      C     <= 1'b0;
      V     <= 1'b0;
    end else if (accept) begin
      ra    <= A;
      rb    <= sub ? ~B : B;
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      ra    <= ra >> 1;
      rb    <= rb >> 1;
      carry <= carry_out;
      acc   <= {sum_bit, acc[WIDTH-1:1]};
      cnt   <= cnt + 1'b1;
      if (cnt == LAST) begin
        // carry still holds the carry into the MSB on this edge
        S <= {sum_bit, acc[WIDTH-1:1]};
        C <= carry_out;
        V <= carry ^ carry_out;
      end
    end
  end

endmodule
